// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: multi-cycle add/subtract that time-shares one 4-bit
// carry-lookahead slice (sum-only) across NIBBLES nibbles, LSB first.
// The inter-nibble carry is kept in a register. The result is returned through
// a valid/ready handshake.
// Optional packed-BCD mode: define CLA_SEQ_BCD_EN. Leave it undefined for pure binary.
module cla_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       w_b_lat;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_sum;
    logic               w_c3;
    logic               w_cout;
    logic               w_commit;
    logic               w_last;
    logic               w_accept;
    logic               w_step;
    logic               w_done;
    logic [3:0]         w_nib_res;
    logic               w_nib_cout;
    logic               w_nib_ovf;

`ifdef CLA_SEQ_BCD_EN
    logic               r_phase;
    logic [3:0]         r_bin_sum;
    logic               r_bin_cout;
    logic               w_adj;
`endif

    // Latch B as stored: true B for add, otherwise its complement.
    always_comb begin
        w_b_lat = b_in;
        if (op_sub) begin
`ifdef CLA_SEQ_BCD_EN
            for (int i = 0; i < int'(NIBBLES); i++) begin
                w_b_lat[4*i +: 4] = 4'(4'd9 - b_in[4*i +: 4]);
            end
`else
            w_b_lat = ~b_in;
`endif
        end
    end

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

    // Shared 4-bit carry-lookahead slice; only its sum leaves the block.
    always_comb begin
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        p    = w_a_nib ^ w_b_nib;
        g    = w_a_nib & w_b_nib;
        c[0] = r_carry;
        c[1] = g[0] | (p[0] & r_carry);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & r_carry);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & r_carry);
        w_sum = p ^ c;
    end

    // Rebuild the MSB carry-in and the carry-out from the sum and operand bits.
    assign w_c3   = w_sum[3] ^ w_a_nib[3] ^ w_b_nib[3];
    assign w_cout = (w_a_nib[3] & w_b_nib[3]) | (w_a_nib[3] & w_c3) | (w_b_nib[3] & w_c3);

`ifdef CLA_SEQ_BCD_EN
    assign w_commit   = r_phase;
    assign w_adj      = r_bin_cout | (r_bin_sum > 4'd9);
    assign w_nib_res  = w_adj ? 4'(r_bin_sum + 4'd6) : r_bin_sum;
    assign w_nib_cout = w_adj;
    assign w_nib_ovf  = 1'b0;
`else
    assign w_commit   = 1'b1;
    assign w_nib_res  = w_sum;
    assign w_nib_cout = w_cout;
    assign w_nib_ovf  = w_c3 ^ w_cout;
`endif

    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and step decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_commit) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            result     <= '0;
            carry_out  <= 1'b0;
            overflow   <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef CLA_SEQ_BCD_EN
            r_phase    <= 1'b0;
            r_bin_sum  <= '0;
            r_bin_cout <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a     <= a_in;
                r_b     <= w_b_lat;
                r_carry <= op_sub;
                r_idx   <= '0;
`ifdef CLA_SEQ_BCD_EN
                r_phase <= 1'b0;
`endif
            end
`ifdef CLA_SEQ_BCD_EN
            if (r_state == S_RUN && !r_phase) begin
                r_bin_sum  <= w_sum;
                r_bin_cout <= w_cout;
                r_phase    <= 1'b1;
            end
`endif
            if (w_step) begin
                result[{r_idx, 2'b00} +: 4] <= w_nib_res;
                r_carry <= w_nib_cout;
                r_idx   <= w_done ? '0 : IDX_W'(r_idx + IDX_W'(1));
`ifdef CLA_SEQ_BCD_EN
                r_phase <= 1'b0;
`endif
                if (w_done) begin
                    carry_out <= w_nib_cout;
                    overflow  <= w_nib_ovf;
                end
            end
            in_ready  <= (w_state_nxt == S_IDLE);
            out_valid <= (w_state_nxt == S_HOLD);
            busy      <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: directed spec vectors plus random operations
// checked against an arithmetic reference model (binary, or BCD when
// CLA_SEQ_BCD_EN is defined).
module tb_cla_nibble_sequencer;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;
`ifdef CLA_SEQ_BCD_EN
    localparam int unsigned LAT = 2 * NIBBLES + 1;
`else
    localparam int unsigned LAT = NIBBLES + 1;
`endif

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int errors = 0;
    int checks = 0;

    cla_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef CLA_SEQ_BCD_EN
    function automatic longint bcd2int(input logic [W-1:0] x);
        longint v = 0;
        for (int i = NIBBLES - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < NIBBLES; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference: modulo 10^NIBBLES, ten's complement on borrow.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W-1:0] r, output logic c, output logic v);
        longint m = 1;
        longint x = bcd2int(a);
        longint y = bcd2int(b);
        for (int i = 0; i < NIBBLES; i++) m = m * 10;
        v = 1'b0;
        if (sub) begin
            c = (x >= y);
            r = int2bcd(c ? x - y : m + x - y);
        end else begin
            c = (x + y >= m);
            r = int2bcd((x + y) % m);
        end
    endtask

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] r;
        for (int i = 0; i < NIBBLES; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction
`else
    // Binary reference: full-width arithmetic, signed overflow from operand/result signs.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W-1:0] r, output logic c, output logic v);
        longint unsigned m  = longint'(1) << W;
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint unsigned s;
        s = sub ? (ua + m - ub) : (ua + ub);
        r = W'(s % m);
        c = (s >= m);
        if (sub) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else     v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        return W'($urandom);
    endfunction
`endif

    // One operation: present, accept, time latency, check, optional backpressure, consume.
    // Caller is positioned just after a negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] er, input logic ec, input logic ev,
                          input int hold, input bit early, input bit pend, input string tag);
        int lat;
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        op_sub    = sub;
        out_ready = early;
        chk({tag, ".in_ready_pre"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = rand_opnd();
        b_in     = rand_opnd();
        op_sub   = 1'($urandom);
        lat      = 1;
        chk({tag, ".busy_run"}, 64'(busy), 64'(1));
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(LAT));
        chk({tag, ".result"}, 64'(result), 64'(er));
        chk({tag, ".carry_out"}, 64'(carry_out), 64'(ec));
        chk({tag, ".overflow"}, 64'(overflow), 64'(ev));
        if (early) begin
            @(negedge clk);
            out_ready = 1'b0;
        end else begin
            for (int i = 0; i < hold; i++) begin
                if (pend) begin
                    in_valid = 1'b1;
                    a_in     = 16'h1111;
                    b_in     = 16'h2222;
                    op_sub   = 1'b0;
                end
                @(negedge clk);
                chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
                chk({tag, ".hold_result"}, 64'(result), 64'(er));
                chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'(0));
        chk({tag, ".idle_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, ".idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W-1:0] er;
        logic         ec;
        logic         ev;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.result", 64'(result), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

`ifdef CLA_SEQ_BCD_EN
        run_op(16'h0958, 16'h0067, 1'b0, 16'h1025, 1'b0, 1'b0, 0, 1'b0, 1'b0, "bcd_add");
        run_op(16'h0100, 16'h0001, 1'b1, 16'h0099, 1'b1, 1'b0, 0, 1'b0, 1'b0, "bcd_sub");
        run_op(16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0, 0, 1'b1, 1'b0, "bcd_sub_neg");
`else
        run_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 0, 1'b0, 1'b0, "add_basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, "add_wrap");
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b1, 1'b0, "add_ovf");
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0, 1'b0, "sub_ovf");
`endif

        // Backpressure with a second request pending; it is taken right after the consume.
        ref_op(16'h0321, 16'h0456, 1'b0, er, ec, ev);
        run_op(16'h0321, 16'h0456, 1'b0, er, ec, ev, 10, 1'b0, 1'b1, "bp_first");
        ref_op(16'h1111, 16'h2222, 1'b0, er, ec, ev);
        run_op(16'h1111, 16'h2222, 1'b0, er, ec, ev, 0, 1'b0, 1'b0, "bp_second");

        // Asynchronous reset while the third nibble is being processed.
        in_valid = 1'b1;
        a_in     = 16'h0987;
        b_in     = 16'h0111;
        op_sub   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst.in_ready", 64'(in_ready), 64'(1));
        chk("midrst.out_valid", 64'(out_valid), 64'(0));
        chk("midrst.result", 64'(result), 64'(0));
        chk("midrst.carry_out", 64'(carry_out), 64'(0));
        chk("midrst.overflow", 64'(overflow), 64'(0));
        chk("midrst.busy", 64'(busy), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0, 1'b0, 1'b0, "post_rst");

        // Random operations with random backpressure and same-cycle consume.
        for (int n = 0; n < 24; n++) begin
            ra = rand_opnd();
            rb = rand_opnd();
            rs = 1'($urandom);
            ref_op(ra, rb, rs, er, ec, ev);
            run_op(ra, rb, rs, er, ec, ev, int'($urandom_range(0, 3)), 1'($urandom), 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
